// File: rtl/pe_wrapper_buffered.sv
// pe_wrapper_buffered
//   Buffered PE wrapper between the PE-array NoC/multicast fabric and one PE
//   core. Fabric side: packed {enable, data} buses. Core side: valid/ready
//   streams. Per-stream FIFOs decouple the two sides; a config FSM latches the
//   packed config word and drains all in-flight data before reconfiguring.
//
//   Optional feature macro: WRAP_PERF_CNT_EN (adds perf_in_stall/perf_out_stall).
//
//   Ports
//     clk, rst (async, active-low), enable (core-side transfer enable)
//     ifmap_in/filter_in/ipsum_in + *_ready     : fabric input streams
//     opsum_out + opsum_ready                   : fabric output stream
//     config_in                                 : {set_info, W, F, S, U, p, q}
//     core_{ifmap,filter,ipsum}[_valid/_ready]  : core input streams
//     core_opsum[_valid/_ready]                 : core output stream
//     core_idle, core_set_info, core_config_*   : config handshake to core
//     cfg_state                                 : IDLE=0, RUN=1, DRAIN=2

module pe_wrapper_buffered_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Depth is a power of 2, so pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module pe_wrapper_buffered #(
   parameter int IFMAP_DATA_SIZE  = 8,
   parameter int FILTER_DATA_SIZE = 8,
   parameter int PSUM_DATA_SIZE   = 8,
   parameter int IFMAP_NUM        = 1,
   parameter int FILTER_NUM       = 4,
   parameter int IPSUM_NUM        = 1,
   parameter int OPSUM_NUM        = 1,
   parameter int IN_FIFO_DEPTH    = 4,
   parameter int OPSUM_FIFO_DEPTH = 2,
   parameter int CONFIG_Q_BIT     = 2,
   parameter int CONFIG_P_BIT     = 5,
   parameter int CONFIG_U_BIT     = 4,
   parameter int CONFIG_S_BIT     = 4,
   parameter int CONFIG_F_BIT     = 12,
   parameter int CONFIG_W_BIT     = 12
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic [IFMAP_NUM*IFMAP_DATA_SIZE:0]     ifmap_in,
   output logic                                   ifmap_ready,
   input  logic [FILTER_NUM*FILTER_DATA_SIZE:0]   filter_in,
   output logic                                   filter_ready,
   input  logic [IPSUM_NUM*PSUM_DATA_SIZE:0]      ipsum_in,
   output logic                                   ipsum_ready,
   output logic [OPSUM_NUM*PSUM_DATA_SIZE:0]      opsum_out,
   input  logic                                   opsum_ready,
   input  logic [CONFIG_Q_BIT+CONFIG_P_BIT+CONFIG_U_BIT+CONFIG_S_BIT+CONFIG_F_BIT+CONFIG_W_BIT:0] config_in,
   output logic [IFMAP_NUM*IFMAP_DATA_SIZE-1:0]   core_ifmap,
   output logic                                   core_ifmap_valid,
   input  logic                                   core_ifmap_ready,
   output logic [FILTER_NUM*FILTER_DATA_SIZE-1:0] core_filter,
   output logic                                   core_filter_valid,
   input  logic                                   core_filter_ready,
   output logic [IPSUM_NUM*PSUM_DATA_SIZE-1:0]    core_ipsum,
   output logic                                   core_ipsum_valid,
   input  logic                                   core_ipsum_ready,
   input  logic [OPSUM_NUM*PSUM_DATA_SIZE-1:0]    core_opsum,
   input  logic                                   core_opsum_valid,
   output logic                                   core_opsum_ready,
   input  logic                                   core_idle,
   output logic                                   core_set_info,
   output logic [CONFIG_Q_BIT-1:0]                core_config_q,
   output logic [CONFIG_P_BIT-1:0]                core_config_p,
   output logic [CONFIG_U_BIT-1:0]                core_config_U,
   output logic [CONFIG_S_BIT-1:0]                core_config_S,
   output logic [CONFIG_F_BIT-1:0]                core_config_F,
   output logic [CONFIG_W_BIT-1:0]                core_config_W,
`ifdef WRAP_PERF_CNT_EN
   output logic [31:0]                            perf_in_stall,
   output logic [31:0]                            perf_out_stall,
`endif
   output logic [1:0]                             cfg_state
);
   localparam int IF_W  = IFMAP_NUM*IFMAP_DATA_SIZE;
   localparam int FL_W  = FILTER_NUM*FILTER_DATA_SIZE;
   localparam int IP_W  = IPSUM_NUM*PSUM_DATA_SIZE;
   localparam int OP_W  = OPSUM_NUM*PSUM_DATA_SIZE;
   localparam int CFG_W = CONFIG_Q_BIT+CONFIG_P_BIT+CONFIG_U_BIT+CONFIG_S_BIT+CONFIG_F_BIT+CONFIG_W_BIT;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } cfg_state_t;

   cfg_state_t       state, state_next;
   logic [CFG_W-1:0] cfg_active;
   logic [CFG_W-1:0] cfg_pending;
   logic             set_pulse;
   logic             load_active;
   logic             load_pending;
   logic             use_pending;
   logic             out_of_reset;

   logic set_info;
   logic [CFG_W-1:0] cfg_fields;
   assign set_info   = config_in[CFG_W];
   assign cfg_fields = config_in[CFG_W-1:0];

   // ---------------- FIFOs ----------------
   logic if_empty, if_full, fl_empty, fl_full, ip_empty, ip_full, op_empty, op_full;
   logic in_accept;
   logic [OP_W-1:0] op_head;

   assign in_accept    = (state == ST_RUN);
   assign ifmap_ready  = !if_full && in_accept;
   assign filter_ready = !fl_full && in_accept;
   assign ipsum_ready  = !ip_full && in_accept;

   assign core_ifmap_valid  = !if_empty && enable;
   assign core_filter_valid = !fl_empty && enable;
   assign core_ipsum_valid  = !ip_empty && enable;

   // Gated by a registered flag so the output ready is low during reset.
   assign core_opsum_ready = !op_full && out_of_reset;
   assign opsum_out        = {!op_empty, op_head};

   pe_wrapper_buffered_fifo #(.W(IF_W), .DEPTH(IN_FIFO_DEPTH)) u_ifmap_fifo (
      .clk(clk), .rst(rst),
      .push(ifmap_in[IF_W] && ifmap_ready), .din(ifmap_in[IF_W-1:0]),
      .pop(core_ifmap_valid && core_ifmap_ready), .dout(core_ifmap),
      .empty(if_empty), .full(if_full));

   pe_wrapper_buffered_fifo #(.W(FL_W), .DEPTH(IN_FIFO_DEPTH)) u_filter_fifo (
      .clk(clk), .rst(rst),
      .push(filter_in[FL_W] && filter_ready), .din(filter_in[FL_W-1:0]),
      .pop(core_filter_valid && core_filter_ready), .dout(core_filter),
      .empty(fl_empty), .full(fl_full));

   pe_wrapper_buffered_fifo #(.W(IP_W), .DEPTH(IN_FIFO_DEPTH)) u_ipsum_fifo (
      .clk(clk), .rst(rst),
      .push(ipsum_in[IP_W] && ipsum_ready), .din(ipsum_in[IP_W-1:0]),
      .pop(core_ipsum_valid && core_ipsum_ready), .dout(core_ipsum),
      .empty(ip_empty), .full(ip_full));

   pe_wrapper_buffered_fifo #(.W(OP_W), .DEPTH(OPSUM_FIFO_DEPTH)) u_opsum_fifo (
      .clk(clk), .rst(rst),
      .push(core_opsum_valid && core_opsum_ready), .din(core_opsum),
      .pop(!op_empty && opsum_ready), .dout(op_head),
      .empty(op_empty), .full(op_full));

   // ---------------- Config FSM ----------------
   logic drained;
   assign drained = if_empty && fl_empty && ip_empty && op_empty && core_idle;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         out_of_reset <= 1'b0;
      end else begin
         state        <= state_next;
         out_of_reset <= 1'b1;
      end
   end

   always_comb begin
      state_next   = state;
      load_active  = 1'b0;
      load_pending = 1'b0;
      use_pending  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (set_info) begin
               load_active = 1'b1;
               state_next  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (set_info) begin
               load_pending = 1'b1;
               state_next   = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (set_info) load_pending = 1'b1;
            // A set_info arriving on the completing cycle is the newest word,
            // so it bypasses the pending register.
            if (drained) begin
               load_active = 1'b1;
               use_pending = !set_info;
               state_next  = ST_RUN;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_active  <= '0;
         cfg_pending <= '0;
         set_pulse   <= 1'b0;
      end else begin
         set_pulse <= load_active;
         if (load_active)  cfg_active  <= use_pending ? cfg_pending : cfg_fields;
         if (load_pending) cfg_pending <= cfg_fields;
      end
   end

   assign core_set_info = set_pulse;
   assign cfg_state     = state;

   localparam int P_LO = CONFIG_Q_BIT;
   localparam int U_LO = P_LO + CONFIG_P_BIT;
   localparam int S_LO = U_LO + CONFIG_U_BIT;
   localparam int F_LO = S_LO + CONFIG_S_BIT;
   localparam int W_LO = F_LO + CONFIG_F_BIT;

   assign core_config_q = cfg_active[CONFIG_Q_BIT-1:0];
   assign core_config_p = cfg_active[U_LO-1:P_LO];
   assign core_config_U = cfg_active[S_LO-1:U_LO];
   assign core_config_S = cfg_active[F_LO-1:S_LO];
   assign core_config_F = cfg_active[W_LO-1:F_LO];
   assign core_config_W = cfg_active[CFG_W-1:W_LO];

`ifdef WRAP_PERF_CNT_EN
   // ---------------- Stall counters (saturating) ----------------
   logic in_stall, out_stall;
   assign in_stall  = (ifmap_in[IF_W] && !ifmap_ready) ||
                      (filter_in[FL_W] && !filter_ready) ||
                      (ipsum_in[IP_W] && !ipsum_ready);
   assign out_stall = opsum_out[OP_W] && !opsum_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_in_stall  <= '0;
         perf_out_stall <= '0;
      end else begin
         if (in_stall && (perf_in_stall != '1))   perf_in_stall  <= perf_in_stall + 32'd1;
         if (out_stall && (perf_out_stall != '1)) perf_out_stall <= perf_out_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pe_wrapper_buffered.sv
// Directed self-checking bench for pe_wrapper_buffered (default parameters).
// Stall-counter checks are compiled in when WRAP_PERF_CNT_EN is defined.
module tb_pe_wrapper_buffered;
   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [8:0]  ifmap_in;
   logic        ifmap_ready;
   logic [32:0] filter_in;
   logic        filter_ready;
   logic [8:0]  ipsum_in;
   logic        ipsum_ready;
   logic [8:0]  opsum_out;
   logic        opsum_ready;
   logic [39:0] config_in;
   logic [7:0]  core_ifmap;
   logic        core_ifmap_valid, core_ifmap_ready;
   logic [31:0] core_filter;
   logic        core_filter_valid, core_filter_ready;
   logic [7:0]  core_ipsum;
   logic        core_ipsum_valid, core_ipsum_ready;
   logic [7:0]  core_opsum;
   logic        core_opsum_valid, core_opsum_ready;
   logic        core_idle;
   logic        core_set_info;
   logic [1:0]  core_config_q;
   logic [4:0]  core_config_p;
   logic [3:0]  core_config_U;
   logic [3:0]  core_config_S;
   logic [11:0] core_config_F;
   logic [11:0] core_config_W;
   logic [1:0]  cfg_state;
`ifdef WRAP_PERF_CNT_EN
   logic [31:0] perf_in_stall, perf_out_stall;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pe_wrapper_buffered dut (
      .clk(clk), .rst(rst), .enable(enable),
      .ifmap_in(ifmap_in), .ifmap_ready(ifmap_ready),
      .filter_in(filter_in), .filter_ready(filter_ready),
      .ipsum_in(ipsum_in), .ipsum_ready(ipsum_ready),
      .opsum_out(opsum_out), .opsum_ready(opsum_ready),
      .config_in(config_in),
      .core_ifmap(core_ifmap), .core_ifmap_valid(core_ifmap_valid), .core_ifmap_ready(core_ifmap_ready),
      .core_filter(core_filter), .core_filter_valid(core_filter_valid), .core_filter_ready(core_filter_ready),
      .core_ipsum(core_ipsum), .core_ipsum_valid(core_ipsum_valid), .core_ipsum_ready(core_ipsum_ready),
      .core_opsum(core_opsum), .core_opsum_valid(core_opsum_valid), .core_opsum_ready(core_opsum_ready),
      .core_idle(core_idle), .core_set_info(core_set_info),
      .core_config_q(core_config_q), .core_config_p(core_config_p), .core_config_U(core_config_U),
      .core_config_S(core_config_S), .core_config_F(core_config_F), .core_config_W(core_config_W),
`ifdef WRAP_PERF_CNT_EN
      .perf_in_stall(perf_in_stall), .perf_out_stall(perf_out_stall),
`endif
      .cfg_state(cfg_state)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [39:0] mk_cfg(input logic [1:0] q, input logic [4:0] p,
                                          input logic [3:0] u, input logic [3:0] s,
                                          input logic [11:0] f, input logic [11:0] w);
      return {1'b1, w, f, s, u, p, q};
   endfunction

   logic [31:0] beats [4];

   initial begin
      beats[0] = 32'h01020304; beats[1] = 32'h05060708;
      beats[2] = 32'h090A0B0C; beats[3] = 32'h0D0E0F10;
      rst = 1'b0; enable = 1'b1;
      ifmap_in = '0; filter_in = '0; ipsum_in = '0; opsum_ready = 1'b0; config_in = '0;
      core_ifmap_ready = 1'b0; core_filter_ready = 1'b0; core_ipsum_ready = 1'b0;
      core_opsum = '0; core_opsum_valid = 1'b0; core_idle = 1'b0;

      // Reset state
      tick(); tick();
      check("rst_ifmap_ready", ifmap_ready, 0);
      check("rst_filter_ready", filter_ready, 0);
      check("rst_ipsum_ready", ipsum_ready, 0);
      check("rst_core_opsum_ready", core_opsum_ready, 0);
      check("rst_valids", {core_ifmap_valid, core_filter_valid, core_ipsum_valid, opsum_out[8]}, 0);
      check("rst_set_info", core_set_info, 0);
      check("rst_state", cfg_state, 0);
      check("rst_config", {core_config_q, core_config_p, core_config_U, core_config_S, core_config_F, core_config_W}, 0);
      rst = 1'b1;
      tick();

      // IDLE refuses data
      ifmap_in = {1'b1, 8'h5A};
      #1;
      check("idle_ifmap_ready", ifmap_ready, 0);
      check("idle_state", cfg_state, 0);
      tick();
      ifmap_in = '0;
      check("idle_no_push", core_ifmap_valid, 0);

      // First configuration
      config_in = mk_cfg(2'd1, 5'd3, 4'd1, 4'd3, 12'd32, 12'd34);
      #1;
      check("pre_set_info", core_set_info, 0);
      tick();
      config_in = '0;
      check("load_set_info", core_set_info, 1);
      check("load_state", cfg_state, 1);
      check("load_q", core_config_q, 1);
      check("load_p", core_config_p, 3);
      check("load_U", core_config_U, 1);
      check("load_S", core_config_S, 3);
      check("load_F", core_config_F, 32);
      check("load_W", core_config_W, 34);
      tick();
      check("set_info_one_cycle", core_set_info, 0);

      // Filter FIFO fill / refuse / drain in order
      check("filter_ready_run", filter_ready, 1);
      for (int i = 0; i < 4; i++) begin
         filter_in = {1'b1, beats[i]};
         tick();
         if (i == 0) begin
            check("filter_latency_valid", core_filter_valid, 1);
            check("filter_latency_data", core_filter, beats[0]);
         end
      end
      check("filter_full_ready", filter_ready, 0);
      filter_in = {1'b1, 32'hDEADBEEF};
      tick();
      filter_in = '0;
      core_filter_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("filter_order_valid", core_filter_valid, 1);
         check("filter_order_data", core_filter, beats[i]);
         tick();
      end
      check("filter_fifth_refused", core_filter_valid, 0);
      check("filter_ready_again", filter_ready, 1);
      core_filter_ready = 1'b0;

      // Opsum FIFO full and ordered drain
      check("opsum_ready_empty", core_opsum_ready, 1);
      core_opsum_valid = 1'b1; core_opsum = 8'h11;
      tick();
      core_opsum = 8'h22;
      tick();
      check("opsum_full_ready", core_opsum_ready, 0);
      check("opsum_head0", opsum_out, {1'b1, 8'h11});
      core_opsum = 8'h33; opsum_ready = 1'b1;
      #1;
      check("opsum_out0", opsum_out, {1'b1, 8'h11});
      tick();
      check("opsum_out1", opsum_out, {1'b1, 8'h22});
      tick();
      core_opsum_valid = 1'b0;
      check("opsum_out2", opsum_out, {1'b1, 8'h33});
      tick();
      check("opsum_empty", opsum_out[8], 0);
      opsum_ready = 1'b0;

      // Reconfiguration drains in-flight data first
      ifmap_in = {1'b1, 8'hA1};
      tick();
      ifmap_in = {1'b1, 8'hA2};
      tick();
      ifmap_in = '0;
      config_in = mk_cfg(2'd1, 5'd3, 4'd1, 4'd5, 12'd32, 12'd34);
      tick();
      config_in = '0;
      check("drain_state", cfg_state, 2);
      check("drain_readys", {ifmap_ready, filter_ready, ipsum_ready}, 0);
      check("drain_old_S", core_config_S, 3);
      check("drain_no_pulse", core_set_info, 0);
      ifmap_in = {1'b1, 8'hFF};
      core_ifmap_ready = 1'b1;
      #1;
      check("drain_pop0", core_ifmap, 8'hA1);
      tick();
      ifmap_in = '0;
      check("drain_pop1", core_ifmap, 8'hA2);
      tick();
      check("drain_empty", core_ifmap_valid, 0);
      tick();
      check("drain_wait_idle", cfg_state, 2);
      core_idle = 1'b1;
      tick();
      check("reload_state", cfg_state, 1);
      check("reload_pulse", core_set_info, 1);
      check("reload_S", core_config_S, 5);
      core_idle = 1'b0; core_ifmap_ready = 1'b0;
      tick();
      check("reload_pulse_end", core_set_info, 0);
      check("drain_push_refused", core_ifmap_valid, 0);
      check("reload_ifmap_ready", ifmap_ready, 1);

      // Core-side enable gating
      ipsum_in = {1'b1, 8'h77};
      tick();
      ipsum_in = '0;
      check("ipsum_valid", core_ipsum_valid, 1);
      enable = 1'b0;
      #1;
      check("enable0_valid", core_ipsum_valid, 0);
      tick();
      check("enable0_hold", core_ipsum_valid, 0);
      enable = 1'b1;
      #1;
      check("enable1_valid", core_ipsum_valid, 1);
      check("enable1_data", core_ipsum, 8'h77);
      core_ipsum_ready = 1'b1;
      tick();
      core_ipsum_ready = 1'b0;
      check("ipsum_popped", core_ipsum_valid, 0);

      // Asynchronous reset mid-operation
      ifmap_in = {1'b1, 8'h3C};
      core_opsum_valid = 1'b1; core_opsum = 8'h55;
      tick();
      ifmap_in = '0; core_opsum_valid = 1'b0;
      check("pre_rst_ifmap_valid", core_ifmap_valid, 1);
      check("pre_rst_opsum_valid", opsum_out[8], 1);
      #2 rst = 1'b0;
      #1;
      check("arst_ifmap_valid", core_ifmap_valid, 0);
      check("arst_opsum_valid", opsum_out[8], 0);
      check("arst_state", cfg_state, 0);
      check("arst_S", core_config_S, 0);
      check("arst_readys", {ifmap_ready, core_opsum_ready}, 0);
      tick();
      rst = 1'b1;

`ifdef WRAP_PERF_CNT_EN
      tick();
      check("perf_in_zero", perf_in_stall, 0);
      check("perf_out_zero", perf_out_stall, 0);
      ifmap_in = {1'b1, 8'h00};
      tick(); tick(); tick();
      ifmap_in = '0;
      check("perf_in_3", perf_in_stall, 3);
      core_opsum_valid = 1'b1; core_opsum = 8'h44;
      tick();
      core_opsum_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("perf_out_10", perf_out_stall, 10);
      #2 rst = 1'b0;
      #1;
      check("perf_rst_out", perf_out_stall, 0);
      check("perf_rst_in", perf_in_stall, 0);
      check("perf_rst_fifo", opsum_out[8], 0);
      check("perf_rst_state", cfg_state, 0);
      tick();
      rst = 1'b1;
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
